color_bbox_locator: RTL and testbench
=====================================

# color_bbox_locator

Consumes the per-pixel locator stream (write strobe, 3-bit binary pixel, 12-bit x/y, done) produced by the sensor pipeline after erosion. For one armed frame, it accumulates a bounding box and a pixel count per colour channel (red = bit 2, green = bit 1, blue = bit 0). At end of frame it latches the results into a read-only register bank for the Avalon-side host. It is the receiving end of the locator interface and sits between the sensor controller and the host slave wrapper.

## Interface
Parameters:
- COORD_W, 12, coordinate width of in_x/in_y
- COUNT_W, 24, per-channel pixel counter width (≤ 32)

Ports:
- in_clock  in  1  locator stream clock; all logic on its rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  arm request, sampled only in IDLE
- in_write  in  1  pixel strobe
- in_pixel  in  3  binary pixel {red, green, blue}
- in_x  in  COORD_W  column of the current pixel
- in_y  in  COORD_W  row of the current pixel
- in_done  in  1  end-of-frame indication (level; rising edge significant)
- read  in  1  register read strobe
- address  in  5  register index
- readdata  out  32  registered read data
- out_busy  out  1  high in ARMED or ACCUM
- out_frame_valid  out  1  one-cycle pulse when new results are latched

## Operation
- States: IDLE, ARMED, ACCUM, LATCH.
  - IDLE: start=1 moves to ARMED and clears the working accumulators.
  - ARMED: in_write=1 with in_x=0 and in_y=0 moves to ACCUM; that pixel is accumulated.
  - ACCUM: accumulates every in_write pixel. A rising edge of in_done (in_done=1 while the previous sample was 0) moves to LATCH.
  - LATCH: copies working registers to result registers, pulses out_frame_valid, then returns to IDLE.
- Per-channel working set:
  - min_x/min_y reset to all-ones; max_x/max_y reset to 0; count reset to 0.
  - For each in_write pixel with the channel bit set: min/max are updated by unsigned compare, and count increments, saturating at 2^COUNT_W−1.
- Empty channel (count=0 at LATCH): result min/max are written as 0 and the empty flag is set.
- start in ARMED, ACCUM or LATCH is ignored. in_done in ARMED is ignored.
- Register map (readdata; unused bits are 0):
  - 0: status — [0] busy, [1] results_valid (set at first LATCH, cleared only by reset), [4:2] empty flags {r,g,b}, [31:16] frame counter (increments at each LATCH, wraps).
  - 4c+1 (c=0 red, 1 green, 2 blue): {min_y at [27:16], min_x at [11:0]}.
  - 4c+2: {max_y, max_x} in the same layout.
  - 4c+3: count, zero-extended.
  - 4c+4 and 13–15: 0.
  - 16–21: centroid sums (see Configuration); 22–31: 0.

## Timing
- Reset (reset_n=0 at a clock edge), effective on that edge:
  - state returns to IDLE.
  - Working and result registers are cleared (min = all-ones in working, 0 in result).
  - Status, frame counter, readdata, out_busy and out_frame_valid all become 0.
- Reset mid-frame discards the partial frame; no out_frame_valid pulse occurs.
- Pixel latency: a pixel sampled at edge N is reflected in the working registers at edge N+1.
- End of frame:
  - in_done rises, sampled at edge N, and the state is ACCUM: LATCH at N+1, results visible and out_frame_valid=1 for cycle N+1..N+2, IDLE at N+2.
  - in_write and an in_done rising edge in the same cycle: that pixel is included in the results.
- Read: read=1 at edge N gives readdata valid after edge N (one-cycle latency). readdata holds its value when read=0.
- Read in the same cycle as LATCH returns the previous results. Result registers change only in LATCH.
- out_busy is a registered state decode, with the same timing as the state.

## Configuration
- LOCATOR_CENTROID_EN defined:
  - Adds 32-bit per-channel sum_x and sum_y accumulators (wrap-around, cleared on arm), latched in LATCH.
  - Readable at 16+2c (sum_x) and 17+2c (sum_y); the host computes centroid = sum/count.
- LOCATOR_CENTROID_EN undefined: no accumulators are instantiated, and addresses 16–21 read 0.

## Test plan
- Reset and idle read: hold reset_n=0 for 2 cycles, then read addresses 0..31 -> all 0; out_busy=0.
- Single red pixel: start, then frame-start pixel (0,0) with pixel=000, red pixel at (100,50), then in_done rise -> one out_frame_valid pulse; addr1=0x00320064, addr2=0x00320064, addr3=1; status empty flags=011, frame counter=1.
- Box and simultaneity: blue pixels at (10,20), (300,5), (40,400); the last one arrives in the same cycle as the in_done rise -> addr9=0x0005000A, addr10=0x0190012C, addr11=3.
- Arming rules: pixels at (5,5) before the (0,0) pixel are ignored; start pulsed during ACCUM is ignored; in_done in ARMED does not latch -> results reflect only post-(0,0) pixels, and out_busy stays 1 until the in_done rise in ACCUM.
- Reset mid-frame: assert reset_n=0 during ACCUM after 10 green pixels -> no out_frame_valid; all registers 0; the next armed frame counts from 0.
- Centroid (LOCATOR_CENTROID_EN defined): green pixels at (2,3) and (4,7) -> addr18=6, addr19=10; with the macro undefined, the same stimulus reads addr18=0.

Source files
------------

// File: rtl/color_bbox_locator_if.sv
// Locator stream plus host register-read bus for color_bbox_locator.
// master = stream/host side, slave = locator.
interface color_bbox_locator_if #(
  parameter int COORD_W = 12
);
  logic               in_write;
  logic [2:0]         in_pixel;
  logic [COORD_W-1:0] in_x;
  logic [COORD_W-1:0] in_y;
  logic               in_done;
  logic               read;
  logic [4:0]         address;
  logic [31:0]        readdata;

  modport master (
    output in_write, in_pixel, in_x, in_y, in_done, read, address,
    input  readdata
  );

  modport slave (
    input  in_write, in_pixel, in_x, in_y, in_done, read, address,
    output readdata
  );
endinterface

// File: rtl/color_bbox_locator.sv
// Per-channel (r/g/b) bounding box and pixel count over one armed frame, latched
// into a host-readable register bank. Optional LOCATOR_CENTROID_EN adds x/y sums.
module color_bbox_locator #(
  parameter int COORD_W = 12,
  parameter int COUNT_W = 24
) (
  input  logic                  in_clock,
  input  logic                  reset_n,
  input  logic                  start,
  color_bbox_locator_if.slave   bus,
  output logic                  out_busy,
  output logic                  out_frame_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    ACCUM = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic done_q;
  logic done_rise;
  logic frame_start;
  logic arm;
  logic accum_en;
  logic [2:0] ch_hit;

  logic [COORD_W-1:0] w_min_x [3];
  logic [COORD_W-1:0] w_min_y [3];
  logic [COORD_W-1:0] w_max_x [3];
  logic [COORD_W-1:0] w_max_y [3];
  logic [COUNT_W-1:0] w_cnt   [3];

  logic [COORD_W-1:0] r_min_x [3];
  logic [COORD_W-1:0] r_min_y [3];
  logic [COORD_W-1:0] r_max_x [3];
  logic [COORD_W-1:0] r_max_y [3];
  logic [COUNT_W-1:0] r_cnt   [3];
  logic [2:0]         r_empty;
  logic               results_valid;
  logic [15:0]        frame_cnt;

`ifdef LOCATOR_CENTROID_EN
  logic [31:0] w_sum_x [3];
  logic [31:0] w_sum_y [3];
  logic [31:0] r_sum_x [3];
  logic [31:0] r_sum_y [3];
`endif

  logic [31:0] rd_mux;
  logic [31:0] readdata_q;

  assign done_rise   = bus.in_done & ~done_q;
  assign frame_start = bus.in_write && (bus.in_x == '0) && (bus.in_y == '0);
  // Channel index 0 = red = pixel bit 2.
  assign ch_hit      = {bus.in_pixel[0], bus.in_pixel[1], bus.in_pixel[2]};

  always_ff @(posedge in_clock) begin
    if (!reset_n) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= bus.in_done;
    end
  end

  always_comb begin
    state_nxt = state;
    arm       = 1'b0;
    accum_en  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ARMED;
          arm       = 1'b1;
        end
      end
      ARMED: begin
        if (frame_start) begin
          state_nxt = ACCUM;
          accum_en  = 1'b1;
        end
      end
      ACCUM: begin
        accum_en = bus.in_write;
        if (done_rise) state_nxt = LATCH;
      end
      LATCH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge in_clock) begin
    if (!reset_n) begin
      out_busy <= 1'b0;
    end else begin
      out_busy <= (state_nxt == ARMED) || (state_nxt == ACCUM);
    end
  end

  // Working accumulators: cleared on reset and on arm, updated per strobed pixel.
  always_ff @(posedge in_clock) begin
    if (!reset_n || arm) begin
      for (int unsigned c = 0; c < 3; c++) begin
        w_min_x[c] <= '1;
        w_min_y[c] <= '1;
        w_max_x[c] <= '0;
        w_max_y[c] <= '0;
        w_cnt[c]   <= '0;
      end
    end else if (accum_en) begin
      for (int unsigned c = 0; c < 3; c++) begin
        if (ch_hit[c]) begin
          if (bus.in_x < w_min_x[c]) w_min_x[c] <= bus.in_x;
          if (bus.in_y < w_min_y[c]) w_min_y[c] <= bus.in_y;
          if (bus.in_x > w_max_x[c]) w_max_x[c] <= bus.in_x;
          if (bus.in_y > w_max_y[c]) w_max_y[c] <= bus.in_y;
          if (w_cnt[c] != '1) w_cnt[c] <= w_cnt[c] + 1'b1;
        end
      end
    end
  end

`ifdef LOCATOR_CENTROID_EN
  always_ff @(posedge in_clock) begin
    if (!reset_n || arm) begin
      for (int unsigned c = 0; c < 3; c++) begin
        w_sum_x[c] <= '0;
        w_sum_y[c] <= '0;
      end
    end else if (accum_en) begin
      for (int unsigned c = 0; c < 3; c++) begin
        if (ch_hit[c]) begin
          w_sum_x[c] <= w_sum_x[c] + 32'(bus.in_x);
          w_sum_y[c] <= w_sum_y[c] + 32'(bus.in_y);
        end
      end
    end
  end

  always_ff @(posedge in_clock) begin
    if (!reset_n) begin
      for (int unsigned c = 0; c < 3; c++) begin
        r_sum_x[c] <= '0;
        r_sum_y[c] <= '0;
      end
    end else if (state == LATCH) begin
      for (int unsigned c = 0; c < 3; c++) begin
        r_sum_x[c] <= w_sum_x[c];
        r_sum_y[c] <= w_sum_y[c];
      end
    end
  end
`endif

  // Result bank: written only in LATCH; empty channels report a zero box.
  always_ff @(posedge in_clock) begin
    if (!reset_n) begin
      for (int unsigned c = 0; c < 3; c++) begin
        r_min_x[c] <= '0;
        r_min_y[c] <= '0;
        r_max_x[c] <= '0;
        r_max_y[c] <= '0;
        r_cnt[c]   <= '0;
      end
      r_empty         <= '0;
      results_valid   <= 1'b0;
      frame_cnt       <= '0;
      out_frame_valid <= 1'b0;
    end else begin
      out_frame_valid <= (state == LATCH);
      if (state == LATCH) begin
        for (int unsigned c = 0; c < 3; c++) begin
          if (w_cnt[c] == '0) begin
            r_min_x[c] <= '0;
            r_min_y[c] <= '0;
            r_max_x[c] <= '0;
            r_max_y[c] <= '0;
            r_empty[c] <= 1'b1;
          end else begin
            r_min_x[c] <= w_min_x[c];
            r_min_y[c] <= w_min_y[c];
            r_max_x[c] <= w_max_x[c];
            r_max_y[c] <= w_max_y[c];
            r_empty[c] <= 1'b0;
          end
          r_cnt[c] <= w_cnt[c];
        end
        results_valid <= 1'b1;
        frame_cnt     <= frame_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (bus.address == 5'd0) begin
      rd_mux[0]     = out_busy;
      rd_mux[1]     = results_valid;
      rd_mux[4:2]   = {r_empty[0], r_empty[1], r_empty[2]};
      rd_mux[31:16] = frame_cnt;
    end
    for (int unsigned c = 0; c < 3; c++) begin
      if (bus.address == 5'(4 * c + 1)) begin
        rd_mux[16 +: COORD_W] = r_min_y[c];
        rd_mux[0 +: COORD_W]  = r_min_x[c];
      end
      if (bus.address == 5'(4 * c + 2)) begin
        rd_mux[16 +: COORD_W] = r_max_y[c];
        rd_mux[0 +: COORD_W]  = r_max_x[c];
      end
      if (bus.address == 5'(4 * c + 3)) begin
        rd_mux[0 +: COUNT_W] = r_cnt[c];
      end
`ifdef LOCATOR_CENTROID_EN
      if (bus.address == 5'(16 + 2 * c)) rd_mux = r_sum_x[c];
      if (bus.address == 5'(17 + 2 * c)) rd_mux = r_sum_y[c];
`endif
    end
  end

  always_ff @(posedge in_clock) begin
    if (!reset_n) begin
      readdata_q <= '0;
    end else if (bus.read) begin
      readdata_q <= rd_mux;
    end
  end

  assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_color_bbox_locator.sv
// Directed bench for color_bbox_locator: frame-level pixel-list model checked every
// cycle, plus literal register expectations for each scenario.
module tb_color_bbox_locator;

  logic in_clock = 1'b0;
  logic reset_n  = 1'b0;
  logic start    = 1'b0;
  logic out_busy;
  logic out_frame_valid;

  color_bbox_locator_if #(.COORD_W(12)) bus ();

  color_bbox_locator #(.COORD_W(12), .COUNT_W(24)) dut (
    .in_clock        (in_clock),
    .reset_n         (reset_n),
    .start           (start),
    .bus             (bus),
    .out_busy        (out_busy),
    .out_frame_valid (out_frame_valid)
  );

  always #5 in_clock = ~in_clock;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: list of accepted pixels for the current frame; results are derived at LATCH.
  typedef struct {
    bit [2:0] p;
    int       x;
    int       y;
  } pix_t;
  pix_t    mq[$];
  int      m_phase;            // 0 idle, 1 armed, 2 accumulating, 3 latching
  bit      m_prev_done;
  int      m_min_x [3];
  int      m_min_y [3];
  int      m_max_x [3];
  int      m_max_y [3];
  int      m_cnt   [3];
  bit [31:0] m_sx  [3];
  bit [31:0] m_sy  [3];
  bit      m_empty [3];
  bit      m_valid;
  int      m_frames;
  bit      m_busy;
  bit [31:0] exp_rd;
  bit      exp_fv;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit [31:0] reg_val(input int a);
    int c;
    int k;
    reg_val = '0;
    if (a == 0) begin
      reg_val = {m_frames[15:0], 11'd0, m_empty[0], m_empty[1], m_empty[2], m_valid, m_busy};
    end else if (a >= 1 && a <= 12) begin
      c = (a - 1) / 4;
      k = (a - 1) % 4;
      if (k == 0) reg_val = (m_min_y[c] << 16) | m_min_x[c];
      if (k == 1) reg_val = (m_max_y[c] << 16) | m_max_x[c];
      if (k == 2) reg_val = m_cnt[c];
    end else if (a >= 16 && a <= 21) begin
`ifdef LOCATOR_CENTROID_EN
      c = (a - 16) / 2;
      reg_val = ((a % 2) == 0) ? m_sx[c] : m_sy[c];
`endif
    end
  endfunction

  function automatic void summarize();
    for (int c = 0; c < 3; c++) begin
      int n = 0;
      int mnx = 4095, mny = 4095, mxx = 0, mxy = 0;
      bit [31:0] sx = 0, sy = 0;
      foreach (mq[i]) begin
        if (mq[i].p[2 - c]) begin
          n++;
          if (mq[i].x < mnx) mnx = mq[i].x;
          if (mq[i].y < mny) mny = mq[i].y;
          if (mq[i].x > mxx) mxx = mq[i].x;
          if (mq[i].y > mxy) mxy = mq[i].y;
          sx += 32'(mq[i].x);
          sy += 32'(mq[i].y);
        end
      end
      m_cnt[c]   = n;
      m_empty[c] = (n == 0);
      m_min_x[c] = (n == 0) ? 0 : mnx;
      m_min_y[c] = (n == 0) ? 0 : mny;
      m_max_x[c] = (n == 0) ? 0 : mxx;
      m_max_y[c] = (n == 0) ? 0 : mxy;
      m_sx[c]    = sx;
      m_sy[c]    = sy;
    end
  endfunction

  task automatic model_reset();
    mq.delete();
    m_phase = 0;
    m_prev_done = 0;
    for (int c = 0; c < 3; c++) begin
      m_min_x[c] = 0; m_min_y[c] = 0; m_max_x[c] = 0; m_max_y[c] = 0;
      m_cnt[c] = 0; m_sx[c] = 0; m_sy[c] = 0; m_empty[c] = 0;
    end
    m_valid = 0; m_frames = 0; m_busy = 0; exp_rd = 0; exp_fv = 0;
  endtask

  // One clock: the model consumes exactly the inputs the DUT sampled on this edge.
  task automatic tick();
    bit rise;
    pix_t px;
    @(posedge in_clock);
    if (!reset_n) begin
      model_reset();
    end else begin
      if (bus.read) exp_rd = reg_val(int'(bus.address));
      exp_fv = 0;
      rise = bus.in_done && !m_prev_done;
      px.p = bus.in_pixel; px.x = int'(bus.in_x); px.y = int'(bus.in_y);
      case (m_phase)
        0: if (start) begin m_phase = 1; mq.delete(); end
        1: if (bus.in_write && px.x == 0 && px.y == 0) begin mq.push_back(px); m_phase = 2; end
        2: begin
          if (bus.in_write) mq.push_back(px);
          if (rise) m_phase = 3;
        end
        default: begin
          summarize();
          m_valid = 1;
          m_frames = (m_frames + 1) & 16'hFFFF;
          exp_fv = 1;
          m_phase = 0;
        end
      endcase
      m_prev_done = bus.in_done;
      m_busy = (m_phase == 1 || m_phase == 2);
    end
    #2;
  endtask

  initial begin
    forever begin
      @(negedge in_clock);
      if (chk_en) begin
        check("readdata", bus.readdata, exp_rd);
        check("out_busy", {31'd0, out_busy}, {31'd0, m_busy});
        check("out_frame_valid", {31'd0, out_frame_valid}, {31'd0, exp_fv});
      end
    end
  end

  task automatic pix(input bit [2:0] p, input int x, input int y);
    bus.in_write = 1'b1;
    bus.in_pixel = p;
    bus.in_x     = 12'(x);
    bus.in_y     = 12'(y);
    tick();
    bus.in_write = 1'b0;
    bus.in_pixel = 3'b000;
  endtask

  task automatic read_chk(input int a, input logic [31:0] e, input string nm);
    bus.read    = 1'b1;
    bus.address = 5'(a);
    tick();
    bus.read    = 1'b0;
    check(nm, bus.readdata, e);
  endtask

  task automatic arm();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Raise in_done for one cycle, then count frame_valid pulses over the next few cycles.
  task automatic finish_frame(input string nm);
    int pulses = 0;
    bus.in_done = 1'b1;
    tick();
    bus.in_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_frame_valid === 1'b1) pulses++;
    end
    check(nm, 32'(pulses), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_write = 1'b0;
    bus.in_pixel = 3'b000;
    bus.in_x     = '0;
    bus.in_y     = '0;
    bus.in_done  = 1'b0;
    bus.read     = 1'b0;
    bus.address  = '0;
    model_reset();

    // Reset and idle reads
    reset_n = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    reset_n = 1'b1;
    for (int a = 0; a < 32; a++) read_chk(a, 32'h0, "idle_read");
    check("idle_busy", {31'd0, out_busy}, 32'd0);

    // Single red pixel
    arm();
    pix(3'b000, 0, 0);
    pix(3'b100, 100, 50);
    finish_frame("red_fv_pulses");
    read_chk(1, 32'h0032_0064, "red_min");
    read_chk(2, 32'h0032_0064, "red_max");
    read_chk(3, 32'd1, "red_count");
    read_chk(0, 32'h0001_000E, "status_f1");

    // Blue box; last pixel coincides with the in_done rise
    arm();
    pix(3'b000, 0, 0);
    pix(3'b001, 10, 20);
    pix(3'b001, 300, 5);
    bus.in_done = 1'b1;
    pix(3'b001, 40, 400);
    bus.in_done = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    read_chk(9,  32'h0005_000A, "blue_min");
    read_chk(10, 32'h0190_012C, "blue_max");
    read_chk(11, 32'd3, "blue_count");
    read_chk(1,  32'h0, "red_empty_min");
    read_chk(0,  32'h0002_001A, "status_f2");

    // Arming rules
    arm();
    pix(3'b111, 5, 5);
    bus.in_done = 1'b1;
    tick();
    bus.in_done = 1'b0;
    tick();
    check("busy_armed", {31'd0, out_busy}, 32'd1);
    pix(3'b010, 0, 0);
    start = 1'b1;
    pix(3'b010, 7, 9);
    start = 1'b0;
    tick();
    check("busy_accum", {31'd0, out_busy}, 32'd1);
    finish_frame("arm_fv_pulses");
    read_chk(5, 32'h0, "green_min");
    read_chk(6, 32'h0009_0007, "green_max");
    read_chk(7, 32'd2, "green_count");
    read_chk(3, 32'd0, "red_ignored");
    read_chk(0, 32'h0003_0016, "status_f3");

    // Reset mid-frame
    arm();
    pix(3'b000, 0, 0);
    for (int i = 0; i < 10; i++) pix(3'b010, i + 1, i + 2);
    begin
      int pulses = 0;
      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
        tick();
        if (out_frame_valid === 1'b1) pulses++;
      end
      reset_n = 1'b1;
      check("midreset_no_fv", 32'(pulses), 32'd0);
    end
    for (int a = 0; a < 13; a++) read_chk(a, 32'h0, "post_reset_read");
    arm();
    pix(3'b010, 0, 0);
    finish_frame("after_reset_fv");
    read_chk(7, 32'd1, "after_reset_count");
    read_chk(0, 32'h0001_0016, "after_reset_status");

    // Centroid sums
    arm();
    pix(3'b000, 0, 0);
    pix(3'b010, 2, 3);
    pix(3'b010, 4, 7);
    finish_frame("centroid_fv");
`ifdef LOCATOR_CENTROID_EN
    read_chk(18, 32'd6,  "green_sum_x");
    read_chk(19, 32'd10, "green_sum_y");
`else
    read_chk(18, 32'd0, "green_sum_x_off");
    read_chk(19, 32'd0, "green_sum_y_off");
`endif
    read_chk(7, 32'd2, "centroid_count");

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
